// File: rtl/frame_sync_ctrl.sv
// Frame-alignment sequencer: hunts, confirms, flywheels and drops sync around the serial pattern detector.
// Define FRAME_CNT_EN to add the 16-bit FRAME_CNT frame counter output.
module frame_sync_ctrl #(
  parameter int FRAME_LEN   = 16,
  parameter int CONFIRM_CNT = 2,
  parameter int MISS_CNT    = 3
) (
  input  logic                         CLK,
  input  logic                         SCLR_N,
  input  logic                         PDET,
  input  logic                         RESYNC,
  output logic                         DET_SCLR,
  output logic                         LOCKED,
  output logic [$clog2(FRAME_LEN)-1:0] BIT_POS,
  output logic                         FRAME_START,
  output logic                         SYNC_ERR,
  output logic                         LOSS,
`ifdef FRAME_CNT_EN
  output logic [15:0]                  FRAME_CNT,
`endif
  output logic [1:0]                   DBG_STATE
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(CONFIRM_CNT + 1);
  localparam int MW = $clog2(MISS_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    VERIFY   = 2'd1,
    LOCK     = 2'd2,
    FLYWHEEL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hit_q, hit_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [CW-1:0] bit_d;
  logic          sclr_d, err_d, loss_d, locked_d, fs_d;
  logic          pdet_v, win, lose;

  assign DBG_STATE = state_q;

  // PDET/RESYNC are single-cycle qualifiers sampled on the edge; there is no backpressure.
  always_comb begin
    state_d  = state_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    bit_d    = (state_q == HUNT || BIT_POS == LAST) ? '0 : BIT_POS + CW'(1);
    sclr_d   = 1'b0;
    err_d    = 1'b0;
    loss_d   = 1'b0;
    lose     = 1'b0;
    // The detector history is invalid in the cycle its clear is visible.
    pdet_v   = PDET & ~DET_SCLR;
    win      = (BIT_POS == LAST);
    if (RESYNC) begin
      state_d = HUNT;
      hit_d   = '0;
      miss_d  = '0;
      bit_d   = '0;
      sclr_d  = 1'b1;
    end else begin
      case (state_q)
        HUNT: begin
          if (pdet_v) begin
            bit_d   = '0;
            hit_d   = HW'(1);
            state_d = (CONFIRM_CNT == 1) ? LOCK : VERIFY;
          end
        end
        VERIFY: begin
          if (win) begin
            if (pdet_v) begin
              hit_d = hit_q + HW'(1);
              if (int'(hit_q) + 1 == CONFIRM_CNT) state_d = LOCK;
            end else begin
              state_d = HUNT;
              hit_d   = '0;
            end
          end
        end
        LOCK, FLYWHEEL: begin
          if (win) begin
            if (pdet_v) begin
              state_d = LOCK;
              miss_d  = '0;
            end else begin
              err_d   = 1'b1;
              miss_d  = miss_q + MW'(1);
              state_d = FLYWHEEL;
              if (int'(miss_q) + 1 == MISS_CNT) lose = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (lose) begin
      loss_d  = 1'b1;
      sclr_d  = 1'b1;
      state_d = HUNT;
      hit_d   = '0;
      miss_d  = '0;
      bit_d   = '0;
    end
    locked_d = (state_d == LOCK) || (state_d == FLYWHEEL);
    fs_d     = locked_d && (bit_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (!SCLR_N) begin
      state_q     <= HUNT;
      hit_q       <= '0;
      miss_q      <= '0;
      BIT_POS     <= '0;
      LOCKED      <= 1'b0;
      FRAME_START <= 1'b0;
      SYNC_ERR    <= 1'b0;
      LOSS        <= 1'b0;
      DET_SCLR    <= 1'b1;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      BIT_POS     <= bit_d;
      LOCKED      <= locked_d;
      FRAME_START <= fs_d;
      SYNC_ERR    <= err_d;
      LOSS        <= loss_d;
      DET_SCLR    <= sclr_d;
    end
  end

`ifdef FRAME_CNT_EN
  // Count tracks FRAME_START in the same cycle; any detector clear restarts it.
  always_ff @(posedge CLK) begin
    if (!SCLR_N || sclr_d) FRAME_CNT <= '0;
    else if (fs_d)         FRAME_CNT <= FRAME_CNT + 16'd1;
  end
`endif

endmodule
